// File: rtl/pccm_ctl_initiator.sv
// Host-side initiator for the 4-bit PCCM control channel: four-phase RTZ handshake with per-phase timeout.
// Optional 4-entry command FIFO in front of IDLE when PCCM_CMD_FIFO_EN is defined.
module pccm_ctl_initiator #(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [3:0] NAK_CODE       = 4'hF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_code,
    output logic       cmd_ready,
    output logic [3:0] pccm_ctl_con_export,
    input  logic [3:0] pccm_rsp_con_export,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_cause
);

    localparam logic [15:0] TMAX = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, REL, WAITZ} state_t;

    state_t     r_state, w_state_nx;
    logic [3:0] r_code, w_code_nx;
    logic [3:0] r_ctl, w_ctl_nx;
    logic [15:0] r_timer, w_timer_nx;
    logic       r_nak, w_nak_nx;
    logic       r_done, r_err;
    logic [1:0] r_cause;
    logic       w_fsm_done, w_fsm_err;
    logic [1:0] w_fsm_cause;
    logic       w_done_nx, w_err_nx;
    logic [1:0] w_cause_nx;
    logic       w_take;
    logic       w_req_valid;
    logic [3:0] w_req_code;
    logic       w_zero_emit;

    always_comb begin
        w_state_nx  = r_state;
        w_code_nx   = r_code;
        w_ctl_nx    = r_ctl;
        w_timer_nx  = r_timer;
        w_nak_nx    = r_nak;
        w_fsm_done  = 1'b0;
        w_fsm_err   = 1'b0;
        w_fsm_cause = r_cause;
        w_take      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_valid) begin
                    w_take = 1'b1;
                    if (w_req_code != 4'd0) begin
                        w_code_nx  = w_req_code;
                        w_ctl_nx   = w_req_code;
                        w_timer_nx = 16'd0;
                        w_nak_nx   = 1'b0;
                        w_state_nx = REQ;
                    end else begin
                        w_fsm_err   = 1'b1;
                        w_fsm_cause = 2'd3;
                    end
                end
            end
            REQ: begin
                // A matching echo beats both NAK and an expiring timer.
                if (pccm_rsp_con_export == r_code) begin
                    w_ctl_nx   = 4'd0;
                    w_state_nx = REL;
                end else if (pccm_rsp_con_export == NAK_CODE) begin
                    w_ctl_nx   = 4'd0;
                    w_nak_nx   = 1'b1;
                    w_state_nx = REL;
                end else if (r_timer == TMAX) begin
                    w_ctl_nx    = 4'd0;
                    w_fsm_err   = 1'b1;
                    w_fsm_cause = 2'd2;
                    w_state_nx  = IDLE;
                end else begin
                    w_timer_nx = r_timer + 16'd1;
                end
            end
            REL: begin
                w_ctl_nx   = 4'd0;
                w_timer_nx = 16'd0;
                w_state_nx = WAITZ;
            end
            WAITZ: begin
                if (pccm_rsp_con_export == 4'd0) begin
                    w_state_nx = IDLE;
                    if (r_nak) begin
                        w_fsm_err   = 1'b1;
                        w_fsm_cause = 2'd1;
                    end else begin
                        w_fsm_done = 1'b1;
                    end
                end else if (r_timer == TMAX) begin
                    w_fsm_err   = 1'b1;
                    w_fsm_cause = 2'd2;
                    w_state_nx  = IDLE;
                end else begin
                    w_timer_nx = r_timer + 16'd1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        w_done_nx  = w_fsm_done;
        w_err_nx   = w_fsm_err;
        w_cause_nx = w_fsm_cause;
        if (w_zero_emit) begin
            w_err_nx   = 1'b1;
            w_cause_nx = 2'd3;
        end
    end

`ifdef PCCM_CMD_FIFO_EN
    logic [3:0] r_fifo [4];
    logic [1:0] r_wr, r_rd;
    logic [2:0] r_cnt;
    logic       r_zpend;
    logic       w_full, w_can_push, w_push, w_zero;

    assign w_full      = (r_cnt == 3'd4);
    assign w_can_push  = !w_full || w_take;
    assign w_push      = cmd_valid && (cmd_code != 4'd0) && w_can_push;
    assign w_zero      = cmd_valid && (cmd_code == 4'd0) && w_can_push;
    assign cmd_ready   = !w_full;
    assign w_req_valid = (r_cnt != 3'd0);
    assign w_req_code  = r_fifo[r_rd];
    // Code-0 rejections are deferred one cycle if they collide with an FSM done/err.
    assign w_zero_emit = (w_zero || r_zpend) && !(w_fsm_done || w_fsm_err);

    always_ff @(posedge Clk) begin
        if (w_push) r_fifo[r_wr] <= cmd_code;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_wr    <= 2'd0;
            r_rd    <= 2'd0;
            r_cnt   <= 3'd0;
            r_zpend <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + 2'd1;
            if (w_take) r_rd <= r_rd + 2'd1;
            r_cnt   <= r_cnt + {2'd0, w_push} - {2'd0, w_take};
            r_zpend <= w_zero_emit ? (w_zero && r_zpend) : (r_zpend || w_zero);
        end
    end
`else
    assign cmd_ready   = (r_state == IDLE);
    assign w_req_valid = cmd_valid;
    assign w_req_code  = cmd_code;
    assign w_zero_emit = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        r_code <= w_code_nx;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_ctl   <= 4'd0;
            r_timer <= 16'd0;
            r_nak   <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cause <= 2'd0;
        end else begin
            r_state <= w_state_nx;
            r_ctl   <= w_ctl_nx;
            r_timer <= w_timer_nx;
            r_nak   <= w_nak_nx;
            r_done  <= w_done_nx;
            r_err   <= w_err_nx;
            r_cause <= w_cause_nx;
        end
    end

    assign pccm_ctl_con_export = r_ctl;
    assign busy                = (r_state != IDLE);
    assign done                = r_done;
    assign err                 = r_err;
    assign err_cause           = r_cause;

endmodule

// File: tb/tb_pccm_ctl_initiator.sv
// Directed, table-driven bench for pccm_ctl_initiator (TIMEOUT_CYCLES=8).
module tb_pccm_ctl_initiator;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       cmd_valid;
    logic [3:0] cmd_code;
    logic       cmd_ready;
    logic [3:0] pccm_ctl_con_export;
    logic [3:0] pccm_rsp_con_export;
    logic       busy, done, err;
    logic [1:0] err_cause;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    pccm_ctl_initiator #(.TIMEOUT_CYCLES(8), .NAK_CODE(4'hF)) dut (
        .Clk(Clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .cmd_ready(cmd_ready), .pccm_ctl_con_export(pccm_ctl_con_export),
        .pccm_rsp_con_export(pccm_rsp_con_export), .busy(busy), .done(done),
        .err(err), .err_cause(err_cause)
    );

    typedef struct {
        logic       v;
        logic [3:0] c;
        logic [3:0] rsp;
        logic [3:0] ctl;
        logic       rdy, bsy, dn, er;
        logic [1:0] cs;
    } vec_t;

    vec_t tbl[27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {22'd0, pccm_ctl_con_export, cmd_ready, busy, done, err, err_cause};
    endfunction

    function automatic logic [31:0] pack(input vec_t t);
        return {22'd0, t.ctl, t.rdy, t.bsy, t.dn, t.er, t.cs};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_ctl(input logic [3:0] want, input string name);
        int n = 0;
        while (pccm_ctl_con_export !== want && n < 20) begin
            tick();
            n++;
        end
        chk(name, {28'd0, pccm_ctl_con_export}, {28'd0, want});
    endtask

    initial begin
        // v  code rsp  ctl rdy bsy dn er cause
        tbl[0]  = '{1, 4'd1, 4'd0, 4'd1, 0, 1, 0, 0, 2'd0};
        tbl[1]  = '{0, 4'd0, 4'd0, 4'd1, 0, 1, 0, 0, 2'd0};
        tbl[2]  = '{0, 4'd0, 4'd0, 4'd1, 0, 1, 0, 0, 2'd0};
        tbl[3]  = '{0, 4'd0, 4'd1, 4'd0, 0, 1, 0, 0, 2'd0};
        tbl[4]  = '{0, 4'd0, 4'd1, 4'd0, 0, 1, 0, 0, 2'd0};
        tbl[5]  = '{0, 4'd0, 4'd0, 4'd0, 1, 0, 1, 0, 2'd0};
        tbl[6]  = '{0, 4'd0, 4'd0, 4'd0, 1, 0, 0, 0, 2'd0};
        tbl[7]  = '{1, 4'd5, 4'd0, 4'd5, 0, 1, 0, 0, 2'd0};
        tbl[8]  = '{0, 4'd0, 4'hF, 4'd0, 0, 1, 0, 0, 2'd0};
        tbl[9]  = '{0, 4'd0, 4'hF, 4'd0, 0, 1, 0, 0, 2'd0};
        tbl[10] = '{0, 4'd0, 4'hF, 4'd0, 0, 1, 0, 0, 2'd0};
        tbl[11] = '{0, 4'd0, 4'd0, 4'd0, 1, 0, 0, 1, 2'd1};
        tbl[12] = '{0, 4'd0, 4'd0, 4'd0, 1, 0, 0, 0, 2'd1};
        tbl[13] = '{1, 4'd0, 4'd0, 4'd0, 1, 0, 0, 1, 2'd3};
        tbl[14] = '{0, 4'd0, 4'd0, 4'd0, 1, 0, 0, 0, 2'd3};
        tbl[15] = '{1, 4'd2, 4'd0, 4'd2, 0, 1, 0, 0, 2'd3};
        for (int i = 16; i <= 22; i++) tbl[i] = '{0, 4'd0, 4'd0, 4'd2, 0, 1, 0, 0, 2'd3};
        // echo arrives on the very cycle the timer reaches its limit: ack wins
        tbl[23] = '{0, 4'd0, 4'd2, 4'd0, 0, 1, 0, 0, 2'd3};
        tbl[24] = '{0, 4'd0, 4'd2, 4'd0, 0, 1, 0, 0, 2'd3};
        tbl[25] = '{0, 4'd0, 4'd0, 4'd0, 1, 0, 1, 0, 2'd3};
        tbl[26] = '{0, 4'd0, 4'd0, 4'd0, 1, 0, 0, 0, 2'd3};

        Reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_code = 4'd0;
        pccm_rsp_con_export = 4'd0;
        #3;
        chk("reset_state", outs(), {22'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
        @(negedge Clk);
        Reset = 1'b1;
        tick();

        for (int i = 0; i < 27; i++) begin
            cmd_valid = tbl[i].v;
            cmd_code = tbl[i].c;
            pccm_rsp_con_export = tbl[i].rsp;
            tick();
            chk($sformatf("vec%0d", i), outs(), pack(tbl[i]));
        end
        cmd_valid = 1'b0;
        pccm_rsp_con_export = 4'd0;

        // timeout: silent responder
        cmd_valid = 1'b1;
        cmd_code = 4'd3;
        tick();
        cmd_valid = 1'b0;
        chk("to_bus_cycle0", {28'd0, pccm_ctl_con_export}, 32'd3);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk($sformatf("to_bus_cycle%0d", k), {28'd0, pccm_ctl_con_export}, 32'd3);
        end
        tick();
        chk("to_abort", outs(), {22'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2});
        tick();
        chk("to_err_clear", {31'd0, err}, 32'd0);

        // asynchronous reset mid-handshake
        cmd_valid = 1'b1;
        cmd_code = 4'd5;
        tick();
        cmd_valid = 1'b0;
        chk("rst_req_bus", {28'd0, pccm_ctl_con_export}, 32'd5);
        #2;
        Reset = 1'b0;
        #1;
        chk("rst_async", outs(), {22'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
        @(negedge Clk);
        Reset = 1'b1;
        // fresh command with response already matching on the first REQ cycle
        pccm_rsp_con_export = 4'd4;
        cmd_valid = 1'b1;
        cmd_code = 4'd4;
        tick();
        cmd_valid = 1'b0;
        chk("post_rst_bus", {28'd0, pccm_ctl_con_export}, 32'd4);
        tick();
        chk("post_rst_ack", {28'd0, pccm_ctl_con_export}, 32'd0);
        pccm_rsp_con_export = 4'd0;
        tick();
        tick();
        chk("post_rst_done", {30'd0, done, err}, 32'd2);

`ifdef PCCM_CMD_FIFO_EN
        begin
            logic [3:0] codes [5];
            int ndone;
            codes = '{4'd1, 4'd5, 4'd2, 4'd7, 4'd4};
            tick();
            for (int i = 0; i < 5; i++) begin
                cmd_valid = 1'b1;
                cmd_code = codes[i];
                tick();
            end
            cmd_valid = 1'b0;
            chk("fifo_full_ready", {31'd0, cmd_ready}, 32'd0);
            ndone = 0;
            for (int i = 0; i < 5; i++) begin
                wait_ctl(codes[i], $sformatf("fifo_bus_code%0d", i));
                pccm_rsp_con_export = codes[i];
                if (done) ndone++;
                tick();
                chk($sformatf("fifo_bus_zero%0d", i), {28'd0, pccm_ctl_con_export}, 32'd0);
                pccm_rsp_con_export = 4'd0;
                for (int k = 0; k < 4; k++) begin
                    if (done) ndone++;
                    if (!done) tick();
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (done) ndone++;
                tick();
            end
            chk("fifo_done_count", ndone, 32'd5);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
